// File: rtl/spart_tx.sv
// spart_tx: SPART transmit path. A one-byte holding register feeds a shift register
// that serialises 8N1 frames (start 0, data LSB first, stop 1) on txd at a programmable
// baud divisor. The divisor is captured per frame, and frames run back-to-back when the
// holding register is already full at the end of a stop bit.
// Ports: clk, rst (async, active-high)
//        tx_load/tx_data : write strobe and byte for the transmit buffer
//        divisor         : clocks per bit (0 and 1 both mean one clock per bit)
//        tbr             : holding register empty
//        tx_busy         : a frame is on the line
//        tx_overrun      : one-cycle pulse, a write was dropped because hold was full
//        txd             : registered serial output
// Build option: define SPART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module spart_tx #(
    parameter int DIV_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_load,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  divisor,
    output logic              tbr,
    output logic              tx_busy,
    output logic              tx_overrun,
    output logic              txd
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
`ifdef SPART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
    logic par_q, par_d;
`endif
    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
    logic              hold_full_q, hold_full_d;
    logic [DIV_W-1:0]  div_q, div_d, baud_q, baud_d, div_eff;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              txd_q, txd_d, ovr_q, ovr_d;
    logic              accept, bit_end, xfer;

    assign div_eff    = (divisor > DIV_W'(1)) ? divisor : DIV_W'(1);
    assign accept     = tx_load & ~hold_full_q;
    assign bit_end    = baud_q == '0;
    // Hold empties into the shift register from IDLE, or straight out of the last
    // stop-bit cycle so consecutive frames have no idle gap.
    assign xfer       = hold_full_q & ((state_q == IDLE) | ((state_q == STOP) & bit_end));
    assign tbr        = ~hold_full_q;
    assign tx_busy    = state_q != IDLE;
    assign tx_overrun = ovr_q;
    assign txd        = txd_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        div_d       = div_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        txd_d       = txd_q;
        hold_d      = accept ? tx_data : hold_q;
        hold_full_d = accept | (hold_full_q & ~xfer);
        ovr_d       = tx_load & hold_full_q;
`ifdef SPART_TX_PARITY_EN
        par_d       = par_q;
`endif
        if (xfer) begin
            state_d = START;
            shift_d = hold_q;
            div_d   = div_eff;
            baud_d  = div_eff - DIV_W'(1);
            txd_d   = 1'b0;
`ifdef SPART_TX_PARITY_EN
            par_d   = ^hold_q;
`endif
        end else if (state_q != IDLE) begin
            baud_d = bit_end ? div_q - DIV_W'(1) : baud_q - DIV_W'(1);
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_d = DATA;
                        txd_d   = shift_q[0];
                        bit_d   = BIT_W'(DATA_W - 1);
                    end
                    DATA: begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q - BIT_W'(1);
`ifdef SPART_TX_PARITY_EN
                        state_d = (bit_q == '0) ? PARITY : DATA;
                        txd_d   = (bit_q == '0) ? par_q : shift_q[1];
`else
                        state_d = (bit_q == '0) ? STOP : DATA;
                        txd_d   = (bit_q == '0) ? 1'b1 : shift_q[1];
`endif
                    end
`ifdef SPART_TX_PARITY_EN
                    PARITY: begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end
`endif
                    default: begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            div_q       <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            txd_q       <= 1'b1;
            ovr_q       <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            txd_q       <= txd_d;
            ovr_q       <= ovr_d;
`ifdef SPART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: checks spart_tx cycle by cycle against a frame-timeline model
module tb_spart_tx;
`ifdef SPART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_load = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic [15:0] divisor = 16'd4;
    logic        tbr, tx_busy, tx_overrun, txd;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    // model: list of frames on the line (start cycle, bit period, byte) plus the pending hold byte
    int         f_start[$];
    int         f_div[$];
    logic [7:0] f_data[$];
    bit         pend = 1'b0;
    int         pend_start = 0;
    logic [7:0] pend_data = 8'h00;
    bit         ovr_exp = 1'b0;
    logic [15:0] dv = 16'd4;

    spart_tx dut (
        .clk(clk), .rst(rst), .tx_load(tx_load), .tx_data(tx_data), .divisor(divisor),
        .tbr(tbr), .tx_busy(tx_busy), .tx_overrun(tx_overrun), .txd(txd)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic got, logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    function automatic int eff(logic [15:0] d);
        return (d < 16'd2) ? 1 : int'(d);
    endfunction

    function automatic int line_end();
        return (f_start.size() == 0) ? 0 : f_start[$] + FL * f_div[$];
    endfunction

    // {busy, txd} expected in cycle t from the frame list
    function automatic logic [1:0] line_at(int t);
        int k;
        logic [7:0] d;
        for (int i = 0; i < f_start.size(); i++) begin
            if (t >= f_start[i] && t < f_start[i] + FL * f_div[i]) begin
                k = (t - f_start[i]) / f_div[i];
                d = f_data[i];
                if (k == 0) return 2'b10;
                if (k <= 8) return {1'b1, d[k-1]};
                if (k == 9 && FL == 11) return {1'b1, ^d};
                return 2'b11;
            end
        end
        return 2'b01;
    endfunction

    task automatic step(bit ld, logic [7:0] dat, logic [15:0] d);
        logic [1:0] ln;
        tx_load = ld;
        tx_data = dat;
        divisor = d;
        @(negedge clk);
        ln = line_at(cyc);
        check("txd", txd, ln[0]);
        check("tx_busy", tx_busy, ln[1]);
        check("tbr", tbr, !pend);
        check("tx_overrun", tx_overrun, ovr_exp);
        ovr_exp = ld && pend;
        if (pend && cyc == pend_start - 1) begin
            f_start.push_back(pend_start);
            f_div.push_back(eff(d));
            f_data.push_back(pend_data);
            pend = 1'b0;
        end else if (ld && !pend) begin
            pend = 1'b1;
            pend_data = dat;
            pend_start = (cyc + 2 > line_end()) ? cyc + 2 : line_end();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n, logic [15:0] d);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, d);
    endtask

    task automatic wait_tbr(logic [15:0] d);
        while (pend) step(1'b0, 8'h00, d);
    endtask

    task automatic drain(logic [15:0] d);
        while (pend || cyc < line_end() + 2) step(1'b0, 8'h00, d);
    endtask

    task automatic model_reset();
        f_start.delete();
        f_div.delete();
        f_data.delete();
        pend = 1'b0;
        ovr_exp = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_txd", txd, 1'b1);
        check("rst_tbr", tbr, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_overrun", tx_overrun, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        model_reset();
        idle(3, 16'd4);
        // single byte, divisor 4
        step(1'b1, 8'h55, 16'd4);
        idle(50, 16'd4);
        // back-to-back at divisor 8
        step(1'b1, 8'h0F, 16'd8);
        wait_tbr(16'd8);
        step(1'b1, 8'hF0, 16'd8);
        drain(16'd8);
        // overrun: third write while hold is full is dropped
        step(1'b1, 8'h11, 16'd4);
        wait_tbr(16'd4);
        step(1'b1, 8'h22, 16'd4);
        step(1'b1, 8'h33, 16'd4);
        drain(16'd4);
        // divisor change mid-frame
        step(1'b1, 8'hC3, 16'd16);
        idle(30, 16'd16);
        idle(20, 16'd4);
        wait_tbr(16'd4);
        step(1'b1, 8'h9A, 16'd4);
        drain(16'd4);
        // divisor 1 and divisor 0
        step(1'b1, 8'h07, 16'd1);
        drain(16'd1);
        step(1'b1, 8'hE1, 16'd0);
        drain(16'd0);
        // asynchronous reset mid-frame with a byte pending in hold
        step(1'b1, 8'hA5, 16'd4);
        idle(2, 16'd4);
        step(1'b1, 8'h3C, 16'd4);
        idle(16, 16'd4);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc += 2;
        model_reset();
        idle(60, 16'd4);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) dv = 16'($urandom_range(0, 5));
            step($urandom_range(0, 3) == 0, 8'($urandom), dv);
        end
        drain(dv);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
